// File: rtl/bnn_ocr_pkg.sv
// Shared command codes, loader state encoding and default geometry for the
// BNN OCR SPI front end.
package bnn_ocr_pkg;

   localparam logic [7:0] CMD_LOAD   = 8'hA5;
   localparam logic [7:0] CMD_STATUS = 8'h5A;
   localparam logic [7:0] CMD_CLEAR  = 8'hC3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RX_IMAGE  = 2'd1,
      IMG_READY = 2'd2
   } loader_state_t;

   localparam int unsigned DEF_IMG_W   = 16;
   localparam int unsigned DEF_IMG_H   = 16;
   localparam int unsigned DEF_CLASS_W = 4;

endpackage

// File: rtl/spi_image_loader.sv
// Command decoder and image packer between the SPI byte receiver and the BNN
// core; also latches the classification result into the SPI status byte.
module spi_image_loader
   import bnn_ocr_pkg::*;
#(
   parameter int unsigned IMG_W   = DEF_IMG_W,
   parameter int unsigned IMG_H   = DEF_IMG_H,
   parameter int unsigned CLASS_W = DEF_CLASS_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_byte,
   input  logic                     byte_valid,
   input  logic                     cs,
   output logic [7:0]               tx_byte,
   output logic [IMG_W*IMG_H-1:0]   image_data,
   output logic                     image_ready,
   input  logic                     image_ack,
   input  logic                     result_valid,
   input  logic [CLASS_W-1:0]       result_class,
   output logic                     busy,
   output logic                     err
);

   localparam int unsigned IMG_BITS  = IMG_W * IMG_H;
   localparam int unsigned IMG_BYTES = IMG_BITS / 8;
   localparam int unsigned CNT_W     = $clog2(IMG_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_BYTES - 1);

   if (CLASS_W > 4 || CLASS_W == 0) begin : gen_class_w_check
      $error("spi_image_loader: CLASS_W must be in 1..4");
   end
   if ((IMG_BITS % 8) != 0 || IMG_BITS < 16) begin : gen_img_bits_check
      $error("spi_image_loader: IMG_W*IMG_H must be a multiple of 8 and at least 16");
   end

   loader_state_t      state;
   logic [CNT_W-1:0]   byte_cnt;
   logic               cs_meta;
   logic               cs_s;
   logic               res_valid;
   logic [CLASS_W-1:0] res_class;
   logic [3:0]         res_class_ext;

   assign res_class_ext = 4'(res_class);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         image_data  <= '0;
         image_ready <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
         res_valid   <= 1'b0;
         res_class   <= '0;
         tx_byte     <= 8'h00;
         cs_meta     <= 1'b1;
         cs_s        <= 1'b1;
      end else begin
         cs_meta <= cs;
         cs_s    <= cs_meta;
         tx_byte <= {res_valid, image_ready, state == RX_IMAGE, err, res_class_ext};

         // Result capture first so that command-driven clears below override it.
         if (result_valid) begin
            res_valid <= 1'b1;
            res_class <= result_class;
         end

         case (state)
            IDLE: begin
               if (byte_valid) begin
                  case (rx_byte)
                     CMD_LOAD: begin
                        state     <= RX_IMAGE;
                        busy      <= 1'b1;
                        byte_cnt  <= '0;
                        res_valid <= 1'b0;
                     end
                     CMD_STATUS: ;
                     CMD_CLEAR: begin
                        image_data <= '0;
                        err        <= 1'b0;
                        res_valid  <= 1'b0;
                        res_class  <= '0;
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end
            RX_IMAGE: begin
               // An accepted byte always wins over a pending chip-select abort.
               if (byte_valid) begin
                  image_data <= {image_data[IMG_BITS-9:0], rx_byte};
                  byte_cnt   <= byte_cnt + 1'b1;
                  if (byte_cnt == LAST_CNT) begin
                     state       <= IMG_READY;
                     image_ready <= 1'b1;
                  end
               end else if (cs_s) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  byte_cnt <= '0;
               end
            end
            IMG_READY: begin
               if (byte_valid && rx_byte == CMD_CLEAR) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  image_ready <= 1'b0;
                  image_data  <= '0;
                  err         <= 1'b0;
               end else begin
                  if (image_ack) begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     image_ready <= 1'b0;
                  end
                  if (byte_valid && rx_byte != CMD_STATUS) begin
                     err <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_image_loader.sv
// Randomised self-checking bench for spi_image_loader against a byte-queue
// reference model of the loader protocol.
module tb_spi_image_loader;

   localparam int unsigned IMG_W     = 16;
   localparam int unsigned IMG_H     = 16;
   localparam int unsigned CLASS_W   = 4;
   localparam int unsigned IMG_BITS  = IMG_W * IMG_H;
   localparam int unsigned IMG_BYTES = IMG_BITS / 8;
   localparam logic [7:0]  C_LOAD    = 8'hA5;
   localparam logic [7:0]  C_STATUS  = 8'h5A;
   localparam logic [7:0]  C_CLEAR   = 8'hC3;

   logic                clk;
   logic                rst;
   logic [7:0]          rx_byte;
   logic                byte_valid;
   logic                cs;
   logic [7:0]          tx_byte;
   logic [IMG_BITS-1:0] image_data;
   logic                image_ready;
   logic                image_ack;
   logic                result_valid;
   logic [CLASS_W-1:0]  result_class;
   logic                busy;
   logic                err;

   int n_cmp = 0;
   int n_bad = 0;

   spi_image_loader #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .CLASS_W (CLASS_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_byte      (rx_byte),
      .byte_valid   (byte_valid),
      .cs           (cs),
      .tx_byte      (tx_byte),
      .image_data   (image_data),
      .image_ready  (image_ready),
      .image_ack    (image_ack),
      .result_valid (result_valid),
      .result_class (result_class),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 receiving, 2 image held for the core.
   int           m_mode;
   int           m_cnt;
   byte unsigned m_hist[$];
   bit           m_err;
   bit           m_rv;
   bit           m_ready;
   bit [3:0]     m_rc;
   bit [7:0]     m_tx;
   bit           m_cs1;
   bit           m_cs2;

   task automatic check(input string tag, input logic [IMG_BITS-1:0] got,
                        input logic [IMG_BITS-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // The image is simply the most recent IMG_BYTES data bytes, oldest in the MSBs.
   function automatic logic [IMG_BITS-1:0] m_image();
      logic [IMG_BITS-1:0] img = '0;
      int n = m_hist.size();
      for (int i = 0; i < n; i++) img[8*(n-1-i) +: 8] = m_hist[i];
      return img;
   endfunction

   task automatic mdl_reset();
      m_mode = 0; m_cnt = 0; m_hist.delete();
      m_err = 0; m_rv = 0; m_ready = 0; m_rc = 0; m_tx = 8'h00;
      m_cs1 = 1; m_cs2 = 1;
   endtask

   task automatic mdl_step();
      bit cs_now = m_cs2;
      m_cs2 = m_cs1;
      m_cs1 = cs;
      m_tx = {m_rv, m_ready, (m_mode == 1), m_err, m_rc};
      if (result_valid) begin
         m_rv = 1;
         m_rc = result_class;
      end
      case (m_mode)
         0: if (byte_valid) begin
            if (rx_byte == C_LOAD) begin
               m_mode = 1; m_cnt = 0; m_rv = 0;
            end else if (rx_byte == C_CLEAR) begin
               m_hist.delete(); m_err = 0; m_rv = 0; m_rc = 0;
            end else if (rx_byte != C_STATUS) begin
               m_err = 1;
            end
         end
         1: if (byte_valid) begin
            m_hist.push_back(rx_byte);
            if (m_hist.size() > IMG_BYTES) void'(m_hist.pop_front());
            m_cnt++;
            if (m_cnt == IMG_BYTES) begin
               m_mode = 2; m_ready = 1;
            end
         end else if (cs_now) begin
            m_mode = 0; m_err = 1; m_cnt = 0;
         end
         default: if (byte_valid && rx_byte == C_CLEAR) begin
            m_ready = 0; m_hist.delete(); m_mode = 0; m_err = 0;
         end else begin
            if (image_ack) begin
               m_ready = 0; m_mode = 0;
            end
            if (byte_valid && rx_byte != C_STATUS) m_err = 1;
         end
      endcase
   endtask

   task automatic check_all();
      check("tx_byte", IMG_BITS'(tx_byte), IMG_BITS'(m_tx));
      check("image_data", image_data, m_image());
      check("image_ready", IMG_BITS'(image_ready), IMG_BITS'(m_ready));
      check("busy", IMG_BITS'(busy), IMG_BITS'(m_mode != 0));
      check("err", IMG_BITS'(err), IMG_BITS'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      mdl_step();
      @(negedge clk);
      check_all();
      byte_valid   = 1'b0;
      image_ack    = 1'b0;
      result_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte    = b;
      byte_valid = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      mdl_reset();
      check_all();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b0; rx_byte = 8'h00; byte_valid = 1'b0; cs = 1'b0;
      image_ack = 1'b0; result_valid = 1'b0; result_class = '0;
      @(negedge clk);
      do_reset();

      // Reset in the middle of an image transfer
      send(C_LOAD);
      for (int i = 0; i < 10; i++) send(8'($urandom));
      @(negedge clk);
      do_reset();
      check("rst_tx", IMG_BITS'(tx_byte), IMG_BITS'(8'h00));
      check("rst_busy", IMG_BITS'(busy), IMG_BITS'(1'b0));

      // Full image 00..1F
      send(C_LOAD);
      for (int i = 0; i < 32; i++) send(8'(i));
      check("ready_after_last", IMG_BITS'(image_ready), IMG_BITS'(1'b1));
      check("img_top_byte", IMG_BITS'(image_data[IMG_BITS-1 -: 8]), IMG_BITS'(8'h00));
      check("img_low_byte", IMG_BITS'(image_data[7:0]), IMG_BITS'(8'h1F));
      tick();
      check("tx_ready_bit", IMG_BITS'(tx_byte[6]), IMG_BITS'(1'b1));
      image_ack = 1'b1;
      tick();
      check("ack_ready", IMG_BITS'(image_ready), IMG_BITS'(1'b0));

      // Command value inside the image is pixel data
      send(C_LOAD);
      for (int i = 0; i < 32; i++) begin
         send((i == 3) ? C_LOAD : 8'($urandom));
         if (i == 3) check("a5_as_data_err", IMG_BITS'(err), IMG_BITS'(1'b0));
      end
      image_ack = 1'b1;
      tick();

      // Chip-select abort then clear
      send(C_LOAD);
      for (int i = 0; i < 5; i++) send(8'($urandom));
      cs = 1'b1;
      repeat (4) tick();
      cs = 1'b0;
      tick();
      check("abort_err", IMG_BITS'(err), IMG_BITS'(1'b1));
      check("abort_tx_err", IMG_BITS'(tx_byte[4]), IMG_BITS'(1'b1));
      repeat (2) tick();
      send(C_CLEAR);
      check("clear_img", image_data, '0);

      // Result latch into the status byte
      result_valid = 1'b1; result_class = 4'd7;
      tick();
      tick();
      check("status_87", IMG_BITS'(tx_byte), IMG_BITS'(8'h87));
      send(C_LOAD);
      tick();
      check("load_tx", IMG_BITS'(tx_byte[7:5]), IMG_BITS'(3'b001));
      for (int i = 0; i < 32; i++) send(8'($urandom));

      // Ack and clear together in IMG_READY
      send(8'h33);
      check("bad_cmd_err", IMG_BITS'(err), IMG_BITS'(1'b1));
      image_ack = 1'b1;
      send(C_CLEAR);
      check("ack_clear_ready", IMG_BITS'(image_ready), IMG_BITS'(1'b0));
      check("ack_clear_err", IMG_BITS'(err), IMG_BITS'(1'b0));
      send(8'h33);
      send(C_LOAD);
      for (int i = 0; i < 32; i++) send(8'($urandom));
      image_ack = 1'b1;
      send(C_CLEAR);
      check("ack_clear_busy", IMG_BITS'(busy), IMG_BITS'(1'b0));
      check("ack_clear_err2", IMG_BITS'(err), IMG_BITS'(1'b0));

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         int r = int'($urandom_range(0, 99));
         if (!cs && $urandom_range(0, 99) < 2) cs = 1'b1;
         else if (cs && $urandom_range(0, 99) < 30) cs = 1'b0;
         if (r < 55) begin
            byte_valid = 1'b1;
            r = int'($urandom_range(0, 99));
            if (m_mode == 0 && r < 40) rx_byte = C_LOAD;
            else if (r < 50) rx_byte = C_STATUS;
            else if (r < 55) rx_byte = C_CLEAR;
            else if (r < 60) rx_byte = C_LOAD;
            else rx_byte = 8'($urandom);
         end
         image_ack    = ($urandom_range(0, 99) < 10);
         result_valid = ($urandom_range(0, 99) < 5);
         result_class = 4'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
